// File: rtl/btn_pkg.sv
// Shared types and defaults for the panel button front end.
//   press_state_t : INC press tracker states (IDLE, PRESSED, LONG)
//   *_DEF         : default debounce / long-press / auto-repeat periods
//   cnt_w()       : counter width for a period, never below 1 bit
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } press_state_t;

  localparam int unsigned DB_CYCLES_DEF     = 1000;
  localparam int unsigned LONG_CYCLES_DEF   = 500000;
  localparam int unsigned REPEAT_CYCLES_DEF = 100000;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter for one button.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous button input, active-high
//   level      : debounced level; flips only after the synchronized input
//                has differed from it for DB_CYCLES consecutive cycles
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      // Only reached below CNT_MAX, so the counter cannot wrap.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/btn_conditioner.sv
// Turns the raw SET / INC / SW panel buttons into single-cycle commands.
// SET and SW pulse on a debounced press. INC pulses `inc` on release of a
// short press and `linc` once a press has been held LONG_CYCLES.
// Optional feature macro: BTN_AUTOREPEAT_EN -- while INC stays held after
// `linc`, emit `inc` every REPEAT_CYCLES cycles.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   btn_set_raw, btn_inc_raw, btn_sw_raw : raw asynchronous buttons
//   set, inc, linc, sw                   : registered one-cycle commands,
//                                          at most one high per cycle
//                                          (set > sw > linc > inc)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set_raw,
  input  logic btn_inc_raw,
  input  logic btn_sw_raw,
  output logic set,
  output logic inc,
  output logic linc,
  output logic sw
);

  // Zero-length periods have no meaningful behaviour; stop elaboration.
  if (DB_CYCLES == 0 || LONG_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_period
    $error("btn_conditioner: all period parameters must be at least 1");
  end

  localparam int unsigned HW = cnt_w(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

  logic set_lvl, inc_lvl, sw_lvl;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .rst_n(rst_n), .raw(btn_set_raw), .level(set_lvl)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .raw(btn_inc_raw), .level(inc_lvl)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw (
    .clk(clk), .rst_n(rst_n), .raw(btn_sw_raw), .level(sw_lvl)
  );

  logic         set_prev_q, set_prev_d;
  logic         inc_prev_q, inc_prev_d;
  logic         sw_prev_q,  sw_prev_d;
  press_state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic         set_q, set_d, inc_q, inc_d, linc_q, linc_d, sw_q, sw_d;
  logic         set_ev, sw_ev, inc_rise, inc_fall, linc_ev, inc_ev;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    set_prev_d = set_lvl;
    inc_prev_d = inc_lvl;
    sw_prev_d  = sw_lvl;
    set_ev     = set_lvl & ~set_prev_q;
    sw_ev      = sw_lvl & ~sw_prev_q;
    inc_rise   = inc_lvl & ~inc_prev_q;
    inc_fall   = ~inc_lvl & inc_prev_q;
    state_d    = state_q;
    hold_d     = hold_q;
    linc_ev    = 1'b0;
    inc_ev     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d      = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (inc_rise) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Release is checked first so a release coinciding with the
        // long-press threshold still counts as a short press.
        if (inc_fall) begin
          inc_ev  = 1'b1;
          state_d = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          linc_ev = 1'b1;
          state_d = LONG;
`ifdef BTN_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG: begin
        if (inc_fall) begin
          state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
        end else if (rpt_q == RPT_MAX) begin
          inc_ev = 1'b1;
          rpt_d  = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Fixed priority; losing events are simply dropped.
    set_d  = set_ev;
    sw_d   = sw_ev & ~set_ev;
    linc_d = linc_ev & ~set_ev & ~sw_ev;
    inc_d  = inc_ev & ~set_ev & ~sw_ev & ~linc_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_prev_q <= 1'b0;
      inc_prev_q <= 1'b0;
      sw_prev_q  <= 1'b0;
      state_q    <= IDLE;
      hold_q     <= '0;
      set_q      <= 1'b0;
      inc_q      <= 1'b0;
      linc_q     <= 1'b0;
      sw_q       <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q      <= '0;
`endif
    end else begin
      set_prev_q <= set_prev_d;
      inc_prev_q <= inc_prev_d;
      sw_prev_q  <= sw_prev_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      set_q      <= set_d;
      inc_q      <= inc_d;
      linc_q     <= linc_d;
      sw_q       <= sw_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign set  = set_q;
  assign inc  = inc_q;
  assign linc = linc_q;
  assign sw   = sw_q;

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end stage that turns the three raw panel buttons (SET, INC, SW) into the clean single-cycle command pulses `set`, `inc`, `linc` and `sw` consumed by the clock/alarm/stopwatch control FSM. Each button is synchronized and debounced. INC additionally gets short-press/long-press discrimination: a short press yields `inc`, and a hold yields `linc`. The block sits between the board pins and the control FSM. It guarantees at most one command pulse per cycle.

## Interface
- `DB_CYCLES`, 1000: debounce window; a level must be stable for this many cycles.
- `LONG_CYCLES`, 500000: hold time after the debounced INC press at which `linc` fires.
- `REPEAT_CYCLES`, 100000: auto-repeat period. Used only when `BTN_AUTOREPEAT_EN` is defined.

- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous assertion, active-low.
- `btn_set_raw` in 1: raw SET button, asynchronous, active-high.
- `btn_inc_raw` in 1: raw INC button, asynchronous, active-high.
- `btn_sw_raw` in 1: raw SW button, asynchronous, active-high.
- `set` out 1: one-cycle pulse on a debounced SET press.
- `inc` out 1: one-cycle pulse on a short INC press, emitted at release.
- `linc` out 1: one-cycle pulse when INC has been held LONG_CYCLES.
- `sw` out 1: one-cycle pulse on a debounced SW press.

## Operation
- **Synchronization:** each raw input passes through a 2-flop synchronizer.
- **Debounce (per button):**
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments.
  - On reaching DB_CYCLES-1, the stable level flips and the counter clears.
  - Glitches shorter than DB_CYCLES never change the stable level.
- **SET, SW:** the pulse is the registered rising edge of the stable level. Release produces nothing.
- **INC press FSM, state IDLE:** on stable rise, go to PRESSED and clear the hold counter.
- **INC press FSM, state PRESSED:** hold counter increments each cycle.
  - Stable fall: emit `inc`, go to IDLE.
  - Hold counter reaches LONG_CYCLES-1: emit `linc`, go to LONG.
  - If both happen in the same cycle, the fall wins and `inc` is emitted.
- **INC press FSM, state LONG:** stable fall goes to IDLE with no pulse. `linc` fires at most once per press.
- **Arbitration:** if several events occur in one cycle, priority is `set` > `sw` > `linc` > `inc`. Lower-priority events are dropped, not queued. At most one output is ever high.
- **Reset values:**
  - All outputs 0.
  - Synchronizer flops, stable levels and counters 0.
  - FSM in IDLE.
- **Reset mid-operation:** any press in progress is discarded and no pulse is emitted. A button still held when `rst_n` deasserts is treated as a fresh press after debounce.
- **Counter widths:** $clog2 of the respective parameter. Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Raw rise to `set`/`sw` pulse: DB_CYCLES+3 cycles (2 synchronizer + DB_CYCLES debounce + 1 output register).
- Raw fall to `inc` pulse: DB_CYCLES+3 cycles.
- Stable INC rise to `linc` pulse: LONG_CYCLES+1 cycles.
- Every pulse is exactly 1 cycle wide.
- The next press of the same button needs a debounced release and re-press.
- Outputs go low asynchronously on `rst_n` assertion. They update only on `clk` after deassertion.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined:** in state LONG, an additional `inc` pulse fires every REPEAT_CYCLES cycles while INC is held. The first repeat comes REPEAT_CYCLES cycles after `linc`. Repeats are subject to normal arbitration. A repeat counter is added.
- **`BTN_AUTOREPEAT_EN` undefined:** no repeat logic exists. LONG only waits for release.

## Structure
- **Package `btn_pkg`:**
  - enum `press_state_t` {IDLE, PRESSED, LONG}.
  - Default constants for DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES.
- **Sub-module `btn_debounce`:** synchronizer plus debounce counter, with parameter DB_CYCLES. Instantiated three times, one per button.
- **Top level:** edge detection, INC press FSM, arbitration and output registers.

## Test plan
Test parameters: DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
- INC raw high for 10 cycles, then low → one `inc` pulse 7 cycles after the fall; `linc` stays 0.
- INC raw held high for 60 cycles → one `linc` at cycle 27 after the rise; no `inc` on release (macro undefined).
- SET raw toggling every 2 cycles for 20 cycles, then held high → exactly one `set` pulse, 7 cycles after the final rise.
- SET and SW raw rising in the same cycle → `set` pulse only; `sw` never asserts for that press.
- `rst_n` low for 3 cycles while INC is in PRESSED (hold counter 10) → all outputs 0, no `linc`. INC still held after release → `linc` 27 cycles after `rst_n` deasserts.
- `BTN_AUTOREPEAT_EN` defined, INC held 50 cycles → `linc`, then `inc` every 5 cycles until release. Macro undefined → no `inc` at all.
